// File: rtl/mem_controller.sv
// mem_controller: round-robin arbiter that multiplexes per-LSU read/write
// requests onto a single external data-memory port, one transaction at a time.
//
// Ports:
//   clk, reset                 - clock and synchronous active-high reset
//   consumer_read_valid/ready  - per-LSU read handshake (ready held until valid drops)
//   consumer_read_address      - packed read addresses, consumer i at [i*ADDR_BITS +: ADDR_BITS]
//   consumer_read_data         - packed read data, consumer i at [i*DATA_BITS +: DATA_BITS]
//   consumer_write_valid/ready - per-LSU write handshake (ready held until valid drops)
//   consumer_write_address/data- packed write address/data, same packing as read
//   mem_read_valid/address     - external read request; mem_read_ready/data complete it
//   mem_write_valid/address/data - external write request; mem_write_ready completes it
module mem_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_e;

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]                   grant_q, grant_d;
  logic                               relay_read_q, relay_read_d;
  logic                               mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]               mem_read_address_q, mem_read_address_d;
  logic                               mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]               mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0]               mem_write_data_q, mem_write_data_d;
  logic [NUM_CONSUMERS-1:0]           c_read_ready_q, c_read_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] c_read_data_q, c_read_data_d;
  logic [NUM_CONSUMERS-1:0]           c_write_ready_q, c_write_ready_d;

  logic             found;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= IDLE;
      rr_ptr_q            <= '0;
      grant_q             <= '0;
      relay_read_q        <= 1'b0;
      mem_read_valid_q    <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      c_read_ready_q      <= '0;
      c_read_data_q       <= '0;
      c_write_ready_q     <= '0;
    end else begin
      state_q             <= state_d;
      rr_ptr_q            <= rr_ptr_d;
      grant_q             <= grant_d;
      relay_read_q        <= relay_read_d;
      mem_read_valid_q    <= mem_read_valid_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_valid_q   <= mem_write_valid_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      c_read_ready_q      <= c_read_ready_d;
      c_read_data_q       <= c_read_data_d;
      c_write_ready_q     <= c_write_ready_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    grant_d             = grant_q;
    relay_read_d        = relay_read_q;
    mem_read_valid_d    = mem_read_valid_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_valid_d   = mem_write_valid_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    c_read_ready_d      = c_read_ready_q;
    c_read_data_d       = c_read_data_q;
    c_write_ready_d     = c_write_ready_q;
    found               = 1'b0;
    idx                 = '0;

    case (state_q)
      IDLE: begin
        // Scan starting at rr_ptr; the found flag keeps only the first hit.
        for (int unsigned off = 0; off < NUM_CONSUMERS; off++) begin
          idx = IDX_W'((32'(rr_ptr_q) + off) % NUM_CONSUMERS);
          if (!found && (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
            found    = 1'b1;
            grant_d  = idx;
            rr_ptr_d = IDX_W'((32'(idx) + 1) % NUM_CONSUMERS);
            // A consumer asserting both is served read first.
            if (consumer_read_valid[idx]) begin
              relay_read_d       = 1'b1;
              mem_read_valid_d   = 1'b1;
              mem_read_address_d = consumer_read_address[idx*ADDR_BITS +: ADDR_BITS];
              state_d            = READ_WAIT;
            end else begin
              relay_read_d        = 1'b0;
              mem_write_valid_d   = 1'b1;
              mem_write_address_d = consumer_write_address[idx*ADDR_BITS +: ADDR_BITS];
              mem_write_data_d    = consumer_write_data[idx*DATA_BITS +: DATA_BITS];
              state_d             = WRITE_WAIT;
            end
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          mem_read_valid_d                                = 1'b0;
          c_read_data_d[grant_q*DATA_BITS +: DATA_BITS]   = mem_read_data;
          c_read_ready_d[grant_q]                         = 1'b1;
          state_d                                         = RELAY;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_write_valid_d        = 1'b0;
          c_write_ready_d[grant_q] = 1'b1;
          state_d                  = RELAY;
        end
      end
      RELAY: begin
        // Release only on the valid matching the completed transaction type.
        if (relay_read_q ? !consumer_read_valid[grant_q] : !consumer_write_valid[grant_q]) begin
          c_read_ready_d  = '0;
          c_write_ready_d = '0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign consumer_read_ready  = c_read_ready_q;
  assign consumer_read_data   = c_read_data_q;
  assign consumer_write_ready = c_write_ready_q;
  assign mem_read_valid       = mem_read_valid_q;
  assign mem_read_address     = mem_read_address_q;
  assign mem_write_valid      = mem_write_valid_q;
  assign mem_write_address    = mem_write_address_q;
  assign mem_write_data       = mem_write_data_q;

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Arbitrates the per-thread load/store unit memory interfaces onto a single external data-memory port.
- Sits directly downstream of the LSUs: it consumes their read/write valid, address and data, and returns ready and read data.
- Round-robin fair; one transaction in flight at a time.
- Uses a valid/ready handshake on both sides.

Parameters:
- NUM_CONSUMERS, 4, number of LSU channels arbitrated.
- ADDR_BITS, 8, memory address width.
- DATA_BITS, 8, memory data width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- consumer_read_valid  input  NUM_CONSUMERS  per-LSU read request.
- consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  packed read addresses; consumer i at bits [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  output  NUM_CONSUMERS  per-LSU read completion.
- consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  packed read data; consumer i at bits [i*DATA_BITS +: DATA_BITS].
- consumer_write_valid  input  NUM_CONSUMERS  per-LSU write request.
- consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS  packed write addresses, same packing as read.
- consumer_write_data  input  NUM_CONSUMERS*DATA_BITS  packed write data, same packing as read.
- consumer_write_ready  output  NUM_CONSUMERS  per-LSU write completion.
- mem_read_valid  output  1  external read request.
- mem_read_address  output  ADDR_BITS  external read address.
- mem_read_ready  input  1  external read done; mem_read_data valid in the same cycle.
- mem_read_data  input  DATA_BITS  external read data.
- mem_write_valid  output  1  external write request.
- mem_write_address  output  ADDR_BITS  external write address.
- mem_write_data  output  DATA_BITS  external write data.
- mem_write_ready  input  1  external write accepted.

Behaviour:
- Reset (synchronous; wins over everything, including mid-transaction):
  - All outputs go to 0. State goes to IDLE. Round-robin pointer rr_ptr goes to 0. Grant register goes to 0.
  - Any in-flight memory request is dropped; no ready is issued to the consumer.
- States: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- IDLE:
  - Scan consumers from rr_ptr upward, modulo NUM_CONSUMERS. The first i with read_valid or write_valid set wins.
  - If the winner asserts both, the read is serviced first; the write is taken on a later grant.
  - On grant: latch i. Set rr_ptr <= (i+1) mod NUM_CONSUMERS.
  - Read grant: mem_read_valid <= 1, mem_read_address <= consumer address, go to READ_WAIT.
  - Write grant: mem_write_valid <= 1, address and data driven from the consumer, go to WRITE_WAIT.
  - No requests: stay in IDLE; rr_ptr unchanged.
- READ_WAIT:
  - Hold mem_read_valid and mem_read_address stable until mem_read_ready is sampled 1.
  - On that edge: mem_read_valid <= 0; consumer_read_data[i] <= mem_read_data; consumer_read_ready[i] <= 1; go to RELAY.
- WRITE_WAIT: same as READ_WAIT using the write signals; on mem_write_ready: mem_write_valid <= 0, consumer_write_ready[i] <= 1, go to RELAY.
- RELAY:
  - Hold ready[i] (and read data) until the granted consumer's corresponding valid is sampled 0.
  - On that edge: clear ready[i] and go to IDLE. The next grant is therefore evaluated in the following cycle.
- Timing: consumer_read_data[i] keeps its last value after completion; other consumers' ready bits stay 0 throughout.
- Latency:
  - Consumer valid sampled at edge E0 → mem_*_valid high after E0.
  - mem ready sampled at E1 → consumer ready high after E1.
  - Minimum request-to-ready is 2 cycles with zero-wait memory.
  - Consumer valid drop sampled at E2 → ready low after E2. Earliest next grant at E3.
- Constraints:
  - At most one of mem_read_valid / mem_write_valid is high at any time.
  - At most one consumer ready bit is high at any time.
- Requests that change while not granted are simply re-sampled in IDLE. Address/data are captured at grant; later changes by the consumer are ignored.
- mem_*_ready asserted while no request is outstanding is ignored.

Test Plan:
- Single read: consumer 2 reads addr 0x3C; memory returns 0xA5 with ready 1 cycle after request → consumer_read_ready[2]=1 with data 0xA5 two edges after valid; drop valid → ready low next edge.
- Single write: consumer 1 writes 0x77 to 0x10; memory holds ready low 3 cycles → mem_write_valid, address 0x10 and data 0x77 stable all 3 cycles; consumer_write_ready[1] pulses only after mem_write_ready.
- Fairness: all 4 consumers hold read valid continuously and release after each ready → grant order 0,1,2,3,0; no consumer serviced twice before others.
- Read/write priority: consumer 0 asserts both read (0x01) and write (0x02) → read issued first, write on a later grant; never both mem valids high.
- Reset mid-transaction: assert reset during READ_WAIT → next cycle all outputs 0, state IDLE; subsequent request from consumer 3 granted first (rr_ptr 0, scan reaches 3) and completes normally.
- Back-pressure in RELAY: consumer holds valid 5 cycles after ready → ready stays high 5 cycles, no new memory request issued meanwhile.
